// File: rtl/calc_pkg.sv
// Status encoding and segment patterns shared between calc and its display stage.
// Segment patterns are active-low with bit 0 = segment a.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_ERRO   = 2'b00,
      ST_BUSY   = 2'b01,
      ST_READY  = 2'b10,
      ST_UNUSED = 2'b11
   } status_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decode; codes 10-15 render blank.
// Zero latency, no flow control.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (value)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_display.sv
// Captures calc's digit stream into a shadow buffer, commits on BUSY->READY and scans it
// onto common-anode displays. Outputs lag the scan index by one cycle; no backpressure.
module calc_display
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int NUM_DIGITS  = 8,
   parameter int BLANK_ZEROS = 1
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            status,
   input  logic [3:0]            data,
   input  logic [3:0]            pos,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

   status_t st;
   status_t status_q;
   logic [3:0] shadow [NUM_DIGITS];
   logic [3:0] disp   [NUM_DIGITS];
   logic       err;
   logic [CW-1:0] cnt;
   logic [SW-1:0] scan;
   logic [NUM_DIGITS-1:0] blank;
   logic       zero_above;
   logic [6:0] dec_seg;
   logic [6:0] next_seg;

   // The unused encoding behaves exactly like BUSY.
   assign st = (status == ST_UNUSED) ? ST_BUSY : status_t'(status);
   assign dp = 1'b1;

   always_comb begin
      zero_above = 1'b1;
      blank      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (disp[i] == 4'd0);
         blank[i]   = (BLANK_ZEROS != 0) && (i != 0) && zero_above;
      end
   end

   seg7_decoder u_dec (
      .value (disp[scan]),
      .seg   (dec_seg)
   );

   always_comb begin
      next_seg = dec_seg;
      if (err) begin
         case (int'(scan))
            0:       next_seg = SEG_O;
            1:       next_seg = SEG_R;
            2:       next_seg = SEG_R;
            3:       next_seg = SEG_E;
            default: next_seg = SEG_BLANK;
         endcase
      end else if (blank[scan]) begin
         next_seg = SEG_BLANK;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= '0;
            disp[i]   <= '0;
         end
         status_q <= ST_READY;
         err      <= 1'b0;
         cnt      <= '0;
         scan     <= '0;
         seg      <= SEG_BLANK;
         an       <= '1;
      end else begin
         status_q <= st;
         if (st == ST_ERRO)
            err <= 1'b1;
         if (st == ST_BUSY && int'(pos) < NUM_DIGITS)
            shadow[pos[SW-1:0]] <= data;
         // Capture needs BUSY now, commit needs READY now, so the two never overlap.
         if (status_q == ST_BUSY && st == ST_READY)
            disp <= shadow;
         if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt  <= '0;
            scan <= (scan == SW'(NUM_DIGITS - 1)) ? '0 : scan + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         an  <= ~(AN_ONE << scan);
         seg <= next_seg;
      end
   end

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with a fast refresh; a second instance shows all zeros.
module tb_calc_display;
   import calc_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] status;
   logic [3:0] data;
   logic [3:0] pos;
   logic [6:0] seg, seg_nb;
   logic       dp, dp_nb;
   logic [7:0] an, an_nb;

   int vectors = 0;
   int miscompares = 0;

   calc_display #(.REFRESH_DIV(4), .NUM_DIGITS(8), .BLANK_ZEROS(1)) dut (
      .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
      .seg(seg), .dp(dp), .an(an)
   );

   calc_display #(.REFRESH_DIV(4), .NUM_DIGITS(8), .BLANK_ZEROS(0)) dut_nb (
      .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
      .seg(seg_nb), .dp(dp_nb), .an(an_nb)
   );

   always #5 clock = ~clock;

   task automatic send_digit(input logic [3:0] p, input logic [3:0] d);
      status = ST_BUSY;
      pos    = p;
      data   = d;
      @(negedge clock);
   endtask

   task automatic commit();
      status = ST_READY;
      @(negedge clock);
      repeat (2) @(negedge clock);
   endtask

   // Walks the scan once and records what each digit shows on both instances.
   task automatic read_screen(output logic [6:0] s1 [8], output logic [6:0] s2 [8],
                              output bit ok);
      logic [7:0] target;
      bit found;
      ok = 1'b1;
      for (int d = 0; d < 8; d++) begin
         target = ~(8'h01 << d);
         found  = 1'b0;
         s1[d]  = 7'hxx;
         s2[d]  = 7'hxx;
         for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clock);
            if (an === target) begin
               s1[d] = seg;
               s2[d] = seg_nb;
               found = 1'b1;
            end
         end
         if (!found) ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      status = ST_READY;
      data   = 4'd0;
      pos    = 4'd0;
      repeat (2) @(negedge clock);
      vectors++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_outputs: an=%h seg=%h dp=%b, want an=ff seg=7f dp=1", an, seg, dp);
      end
      reset = 1'b1;
      @(negedge clock);
      vectors++;
      if (an !== 8'hFE || seg !== 7'h40) begin
         miscompares++;
         $display("FAIL reset_first_digit: an=%h seg=%h, want an=fe seg=40", an, seg);
      end
   endtask

   task automatic test_capture();
      logic [6:0] s1 [8], s2 [8];
      logic [6:0] e1 [8] = '{7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      logic [6:0] e2 [8] = '{7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      logic [3:0] v  [8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      bit ok;
      for (int i = 0; i < 8; i++) send_digit(4'(i), v[i]);
      commit();
      read_screen(s1, s2, ok);
      for (int d = 0; d < 8; d++) begin
         vectors++;
         if (!ok || s1[d] !== e1[d] || s2[d] !== e2[d]) begin
            miscompares++;
            $display("FAIL capture_123 digit%0d: seg=%h/%h, want %h/%h", d, s1[d], s2[d], e1[d], e2[d]);
         end
      end
   endtask

   task automatic test_zero();
      logic [6:0] s1 [8], s2 [8];
      bit ok;
      for (int i = 0; i < 8; i++) send_digit(4'(i), 4'd0);
      commit();
      read_screen(s1, s2, ok);
      for (int d = 0; d < 8; d++) begin
         vectors++;
         if (!ok || s1[d] !== ((d == 0) ? 7'h40 : 7'h7F) || s2[d] !== 7'h40) begin
            miscompares++;
            $display("FAIL zero_value digit%0d: seg=%h/%h, want %h/40", d, s1[d], s2[d],
                     (d == 0) ? 7'h40 : 7'h7F);
         end
      end
   endtask

   task automatic test_scan_timing();
      logic [7:0] prev;
      logic [7:0] want;
      int n;
      bit found = 1'b0;
      for (int c = 0; c < 64 && !found; c++) begin
         @(negedge clock);
         found = (an === 8'h7F);
      end
      prev = an;
      for (int c = 0; c < 10 && found; c++) begin
         @(negedge clock);
         if (an !== prev) break;
      end
      vectors++;
      if (!found || an !== 8'hFE) begin
         miscompares++;
         $display("FAIL scan_sync: an=%h, want fe", an);
      end
      for (int k = 1; k <= 8; k++) begin
         prev = an;
         n = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            n++;
            if (an !== prev) break;
         end
         want = ~(8'h01 << (k % 8));
         vectors++;
         if (n !== 4 || an !== want) begin
            miscompares++;
            $display("FAIL scan_step%0d: edges=%0d an=%h, want edges=4 an=%h", k, n, an, want);
         end
      end
   endtask

   task automatic test_error();
      logic [6:0] s1 [8], s2 [8];
      logic [6:0] e  [8] = '{7'h23, 7'h2F, 7'h2F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      bit ok;
      status = ST_ERRO;
      @(negedge clock);
      commit();
      read_screen(s1, s2, ok);
      for (int d = 0; d < 8; d++) begin
         vectors++;
         if (!ok || s1[d] !== e[d] || s2[d] !== e[d]) begin
            miscompares++;
            $display("FAIL error_screen digit%0d: seg=%h/%h, want %h", d, s1[d], s2[d], e[d]);
         end
      end
      send_digit(4'd0, 4'd7);
      commit();
      repeat (20) @(negedge clock);
      read_screen(s1, s2, ok);
      vectors++;
      if (!ok || s1[0] !== 7'h23 || s1[3] !== 7'h06) begin
         miscompares++;
         $display("FAIL error_sticky: d0=%h d3=%h, want 23 06", s1[0], s1[3]);
      end
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      read_screen(s1, s2, ok);
      vectors++;
      if (!ok || s1[0] !== 7'h40 || s1[3] !== 7'h7F || s2[3] !== 7'h40) begin
         miscompares++;
         $display("FAIL error_cleared: d0=%h d3=%h/%h, want 40 7f/40", s1[0], s1[3], s2[3]);
      end
   endtask

   task automatic test_reset_mid_capture();
      logic [6:0] s1 [8], s2 [8];
      bit ok;
      send_digit(4'd0, 4'd5);
      send_digit(4'd1, 4'd6);
      send_digit(4'd2, 4'd7);
      send_digit(4'd3, 4'd8);
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (an !== 8'hFF || seg !== 7'h7F) begin
         miscompares++;
         $display("FAIL midcap_reset: an=%h seg=%h, want ff 7f", an, seg);
      end
      reset  = 1'b1;
      status = ST_READY;
      @(negedge clock);
      read_screen(s1, s2, ok);
      vectors++;
      if (!ok || s1[0] !== 7'h40 || s1[1] !== 7'h7F || s2[2] !== 7'h40) begin
         miscompares++;
         $display("FAIL midcap_no_commit: d0=%h d1=%h nb_d2=%h, want 40 7f 40", s1[0], s1[1], s2[2]);
      end
      send_digit(4'd0, 4'd4);
      send_digit(4'd1, 4'd5);
      read_screen(s1, s2, ok);
      vectors++;
      if (!ok || s1[0] !== 7'h40) begin
         miscompares++;
         $display("FAIL midcap_busy_hold: d0=%h, want 40", s1[0]);
      end
      commit();
      read_screen(s1, s2, ok);
      vectors++;
      if (!ok || s1[0] !== 7'h19 || s1[1] !== 7'h12 || s1[2] !== 7'h7F
              || s2[2] !== 7'h40 || s2[3] !== 7'h40) begin
         miscompares++;
         $display("FAIL midcap_resume: d0=%h d1=%h d2=%h nb_d2=%h nb_d3=%h, want 19 12 7f 40 40",
                  s1[0], s1[1], s1[2], s2[2], s2[3]);
      end
   endtask

   task automatic test_invalid_inputs();
      logic [6:0] s1 [8], s2 [8];
      bit ok;
      send_digit(4'd0, 4'd12);
      send_digit(4'd9, 4'd7);
      commit();
      read_screen(s1, s2, ok);
      vectors++;
      if (!ok || s1[0] !== 7'h7F || s2[0] !== 7'h7F) begin
         miscompares++;
         $display("FAIL value12_blank: d0=%h/%h, want 7f", s1[0], s2[0]);
      end
      vectors++;
      if (!ok || s1[1] !== 7'h12 || s2[1] !== 7'h12 || s1[2] !== 7'h7F || s2[2] !== 7'h40) begin
         miscompares++;
         $display("FAIL pos9_ignored: d1=%h/%h d2=%h/%h, want 12/12 7f/40", s1[1], s2[1], s1[2], s2[2]);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_zero();
      test_scan_timing();
      test_error();
      test_reset_mid_capture();
      test_invalid_inputs();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
